// File: rtl/syn_fifo_fwft.sv
// syn_fifo_fwft: single-clock FIFO with selectable standard / first-word-fall-through
// read mode, occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
module syn_fifo_fwft #(
    parameter int FIFO_ENTRIES = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int FWFT         = 0,
    parameter int AF_LEVEL     = FIFO_ENTRIES - 2,
    parameter int AE_LEVEL     = 2
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              flush,
    input  logic                              wr_en,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              valid,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [$clog2(FIFO_ENTRIES):0]     count,
    output logic [$clog2(FIFO_ENTRIES)-1:0]   w_index,
    output logic [$clog2(FIFO_ENTRIES)-1:0]   r_index,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int AW = $clog2(FIFO_ENTRIES);
    localparam int CW = AW + 1;

    // Threshold helpers: flags are always derived from the post-update count.
    function automatic logic af_of(input logic [CW-1:0] c);
        return (int'(c) >= AF_LEVEL);
    endfunction

    function automatic logic ae_of(input logic [CW-1:0] c);
        return (int'(c) <= AE_LEVEL);
    endfunction

    logic [DATA_WIDTH-1:0] mem_array_r [FIFO_ENTRIES];
    logic [AW-1:0]         w_idx_r;
    logic [AW-1:0]         r_idx_r;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  af_r;
    logic                  ae_r;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // A read never comes from an empty FIFO; a write into a full FIFO is
    // only taken when a read frees a slot on the same edge.
    assign rd_acc_s = rd_en & ~empty_r;
    assign wr_acc_s = wr_en & (~full_r | rd_acc_s);

    // Next occupancy: simultaneous accepted write and read cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (wr_acc_s && !flush) begin
            mem_array_r[w_idx_r] <= data_in;
        end
    end

    // Pointers, count, registered status flags and sticky error flags.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            w_idx_r <= {AW{1'b0}};
            r_idx_r <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= af_of({CW{1'b0}});
            ae_r    <= ae_of({CW{1'b0}});
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (flush) begin
            w_idx_r <= {AW{1'b0}};
            r_idx_r <= {AW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= af_of({CW{1'b0}});
            ae_r    <= ae_of({CW{1'b0}});
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                w_idx_r <= w_idx_r + AW'(1);
            end
            if (rd_acc_s) begin
                r_idx_r <= r_idx_r + AW'(1);
            end
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == CW'(FIFO_ENTRIES));
            empty_r <= (cnt_nxt_s == {CW{1'b0}});
            af_r    <= af_of(cnt_nxt_s);
            ae_r    <= ae_of(cnt_nxt_s);
            if (wr_en && !wr_acc_s) begin
                ovf_r <= 1'b1;
            end
            if (rd_en && empty_r) begin
                unf_r <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented as soon as it exists; zero while empty.
            assign data_out = empty_r ? {DATA_WIDTH{1'b0}} : mem_array_r[r_idx_r];
            assign valid    = ~empty_r;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_r;
            logic                  valid_r;

            // Registered read port: one-cycle latency, data holds between reads.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    dout_r  <= {DATA_WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end else if (flush) begin
                    dout_r  <= {DATA_WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end else if (rd_acc_s) begin
                    dout_r  <= mem_array_r[r_idx_r];
                    valid_r <= 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end

            assign data_out = dout_r;
            assign valid    = valid_r;
        end
    endgenerate

    assign count        = cnt_r;
    assign w_index      = w_idx_r;
    assign r_index      = r_idx_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// Bench for syn_fifo_fwft: a standard-mode and an FWFT-mode instance share the
// same stimulus; a queue scoreboard plus small model supplies every expectation.
module tb_syn_fifo_fwft;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;

    logic [7:0] s_dout, f_dout;
    logic       s_valid, f_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae;
    logic [4:0] s_cnt, f_cnt;
    logic [3:0] s_wi, f_wi, s_ri, f_ri;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int errors = 0;
    int checks = 0;

    // model state
    logic [7:0] q[$];
    int         m_w, m_r;
    logic       m_ovf, m_unf, m_valid;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    syn_fifo_fwft #(.FIFO_ENTRIES(N), .DATA_WIDTH(8), .FWFT(0)) u_std (
        .sys_clk(clk), .sys_rst(sys_rst), .flush(flush), .wr_en(wr_en),
        .data_in(data_in), .rd_en(rd_en), .data_out(s_dout), .valid(s_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_cnt), .w_index(s_wi), .r_index(s_ri),
        .overflow(s_ovf), .underflow(s_unf)
    );

    syn_fifo_fwft #(.FIFO_ENTRIES(N), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
        .sys_clk(clk), .sys_rst(sys_rst), .flush(flush), .wr_en(wr_en),
        .data_in(data_in), .rd_en(rd_en), .data_out(f_dout), .valid(f_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_cnt), .w_index(f_wi), .r_index(f_ri),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_w = 0; m_r = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        m_valid = 1'b0; m_dout = 8'h00;
    endtask

    task automatic check_all(input string ph);
        int sz;
        logic [7:0] head;
        sz = q.size();
        head = (sz != 0) ? q[0] : 8'h00;
        chk({ph, ".s_cnt"},   s_cnt,   sz);
        chk({ph, ".f_cnt"},   f_cnt,   sz);
        chk({ph, ".s_full"},  s_full,  (sz == N));
        chk({ph, ".f_full"},  f_full,  (sz == N));
        chk({ph, ".s_empty"}, s_empty, (sz == 0));
        chk({ph, ".s_af"},    s_af,    (sz >= 14));
        chk({ph, ".f_af"},    f_af,    (sz >= 14));
        chk({ph, ".s_ae"},    s_ae,    (sz <= 2));
        chk({ph, ".s_wi"},    s_wi,    m_w);
        chk({ph, ".s_ri"},    s_ri,    m_r);
        chk({ph, ".f_wi"},    f_wi,    m_w);
        chk({ph, ".f_ri"},    f_ri,    m_r);
        chk({ph, ".s_ovf"},   s_ovf,   m_ovf);
        chk({ph, ".s_unf"},   s_unf,   m_unf);
        chk({ph, ".f_ovf"},   f_ovf,   m_ovf);
        chk({ph, ".f_unf"},   f_unf,   m_unf);
        chk({ph, ".s_valid"}, s_valid, m_valid);
        chk({ph, ".s_dout"},  s_dout,  m_dout);
        chk({ph, ".f_valid"}, f_valid, (sz != 0));
        chk({ph, ".f_dout"},  f_dout,  head);
    endtask

    // One clock of stimulus: the model pops the expected read word (scoreboard)
    // and pushes accepted writes, then everything is compared after the edge.
    task automatic step(input string ph, input logic w, input logic [7:0] d,
                        input logic r, input logic f);
        logic e, fu, ra, wa;
        wr_en = w; data_in = d; rd_en = r; flush = f;
        if (f) begin
            model_reset();
        end else begin
            e  = (q.size() == 0);
            fu = (q.size() == N);
            ra = r && !e;
            wa = w && (!fu || ra);
            if (ra) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
                m_r     = (m_r + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
            if (wa) begin
                q.push_back(d);
                m_w = (m_w + 1) % N;
            end
            if (w && !wa) m_ovf = 1'b1;
            if (r && e)   m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(ph);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        model_reset();
        #3;
        check_all("reset");
        #4;
        sys_rst = 1'b0;

        // 1: fill with 0x01..0x10, pointer wraps, then overflow
        for (int i = 0; i < N; i++) step("fill", 1'b1, 8'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("mem%0d", i), u_std.mem_array_r[i], i + 1);
        step("ovf", 1'b1, 8'h11, 1'b0, 1'b0);
        chk("ovf.mem0", u_std.mem_array_r[0], 32'h01);

        // 2: drain in order, then underflow with data_out held
        for (int i = 0; i < N; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf.hold", s_dout, 32'h10);

        // 3: FWFT fall-through and acknowledge
        step("flush1", 1'b0, 8'h00, 1'b0, 1'b1);
        step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft.dout", f_dout, 32'hA5);
        step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // 4/5: threshold walk while refilling, then write+read when full
        step("flush2", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) step("walk", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'h3C, 1'b1, 1'b0);
        chk("full_wr_rd.mem0", u_std.mem_array_r[0], 32'h3C);
        for (int i = 0; i < N; i++) step("walk_dn", 1'b0, 8'h00, 1'b1, 1'b0);

        // 6: alternating traffic, flush with write, async reset mid-burst
        step("flush3", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 48; i++) begin
            step("alt", (i % 2) == 0, 8'(i * 3), (i % 2) == 1, 1'b0);
            if ((i % 2) == 1) chk("alt.idx_eq", s_ri, m_w);
        end
        step("pre_flush", 1'b1, 8'h77, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 8'h99, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("burst", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        wr_en = 1'b1; data_in = 8'h5F;
        #3;
        sys_rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        wr_en = 1'b0;
        @(negedge clk);
        sys_rst = 1'b0;
        step("post_rst", 1'b1, 8'hC3, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/syn_fifo_fwft.md
Name: syn_fifo_fwft

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Sits between a producer and a consumer in the same clock domain; exposes slot indices so benches can check storage directly.

Parameters:
- FIFO_ENTRIES, 16, depth; power of two, >= 2.
- DATA_WIDTH, 8, data word width.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, FIFO_ENTRIES-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- sys_clk  in  1  single clock; all state changes on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO state.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop/acknowledge in FWFT mode).
- data_out  out  DATA_WIDTH  read data.
- valid  out  1  data_out holds a valid word.
- full  out  1  count == FIFO_ENTRIES.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(FIFO_ENTRIES)+1  number of stored words.
- w_index  out  $clog2(FIFO_ENTRIES)  slot the next write goes to.
- r_index  out  $clog2(FIFO_ENTRIES)  slot the next read comes from.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (sys_rst high, asynchronous) clears the following to 0:
  - pointers, count, data_out, valid, overflow and underflow;
  - full and almost_full (unless AF_LEVEL == 0).
- Reset sets empty = 1 and almost_empty = 1.
- mem_array is not reset. Reset asserted mid-operation discards all contents.
- flush has the highest synchronous priority. On a flush edge:
  - all state takes the reset values;
  - wr_en and rd_en in the same cycle are ignored.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc).
  - On an accepted write, mem_array[w_index] <= data_in and w_index increments modulo FIFO_ENTRIES.
- Read acceptance: rd_acc = rd_en & !empty.
  - A read is never accepted from an empty FIFO, even with a write in the same cycle.
  - On an accepted read, r_index increments modulo FIFO_ENTRIES.
- Count update:
  - +1 on write only;
  - -1 on read only;
  - unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are registered. They update on the same edge as count and reflect the new count.
- Simultaneous write and read when full: both are accepted, count stays FIFO_ENTRIES and no overflow is flagged.
- Rejected requests:
  - wr_en & !wr_acc sets overflow;
  - rd_en & empty sets underflow;
  - both flags hold until reset or flush. Rejected requests leave data and pointers unchanged.
- Standard mode (FWFT = 0):
  - an accepted read at edge N drives data_out = mem_array[old r_index] and valid = 1 after edge N (1-cycle latency);
  - valid drops after the next edge that has no accepted read;
  - data_out holds its last value otherwise.
- FWFT mode (FWFT = 1):
  - data_out = mem_array[r_index] combinationally; valid = !empty;
  - rd_en acts as acknowledge and pops the word;
  - a word written at edge N is visible with valid = 1 after edge N.
- Wrap-around: both pointers wrap from FIFO_ENTRIES-1 to 0 with no bubble. Full vs empty is resolved by count, not pointer equality.

Test Plan:
1. Reset, then 16 writes of 0x01..0x10 -> w_index wraps to 0, count = 16, full = 1, almost_full = 1, mem_array[i] = i+1, overflow = 0; a 17th write -> overflow = 1, mem_array[0] still 0x01.
2. FWFT = 0, after scenario 1: 16 reads -> data_out = 0x01..0x10 in order, each with valid = 1 one cycle after rd_en; then a read on empty -> underflow = 1, data_out stays 0x10.
3. FWFT = 1: write 0xA5 at edge N -> valid = 1, data_out = 0xA5 after edge N; rd_en for one cycle -> empty = 1, valid = 0.
4. Full FIFO, wr_en & rd_en together with data_in 0x3C -> count stays 16, oldest word popped, 0x3C stored at the old w_index, overflow = 0.
5. Threshold walk with AF_LEVEL = 14, AE_LEVEL = 2 -> almost_empty = 1 for count 0..2 and 0 at count 3; almost_full = 0 at count 13 and 1 at count 14.
6. 48 alternating write/read cycles, then flush with wr_en high, then sys_rst pulsed mid-burst -> w_index == r_index at every read, count = 0 after the flush with the write ignored, all outputs at reset values immediately on sys_rst.
